chnlnk_frame_fsm_p: RTL and testbench
=====================================

# chnlnk_frame_fsm_p

Parametrised channel-link frame sequencer, the next generation of the fixed 96+4 word frame FSM. It pops sample data from the channel FIFO, emits a sequence-numbered frame of DATA_WORDS data words followed by TAIL_WORDS tail words, and flags the last word of an event. New in this generation:
- frame geometry is set by parameters;
- a Pause state stalls the frame when the FIFO underruns mid-sample;
- triplication is optional, with a sticky replica-mismatch flag;
- a per-event sample counter is provided.

## Interface
Parameters:
- DATA_WORDS, 96, data words per sample (SEQ 0..DATA_WORDS-1); 2..(2^SEQ_W - TAIL_WORDS)
- TAIL_WORDS, 4, tail words per sample (SEQ DATA_WORDS..DATA_WORDS+TAIL_WORDS-1); ≥1
- SEQ_W, 7, width of SEQ; 2^SEQ_W ≥ DATA_WORDS+TAIL_WORDS
- SCNT_W, 5, width of SAMPLE_CNT
- TMR, 1, 1 = triplicated state/datapath with majority voting; 0 = single copy, TMR_ERR tied 0

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- L1A_BUF_MT  in  1  L1A buffer empty; 0 = event pending
- F_MT  in  1  sample FIFO empty
- END_EVT  in  1  current sample is the last of its event; sampled on the final data word
- CLR_TMR_ERR  in  1  synchronous clear of TMR_ERR
- RD  out  1  FIFO pop strobe, registered
- VALID  out  1  output word valid, registered
- SEQ  out  SEQ_W  sequence number of the current word, registered
- CLR_CRC  out  1  CRC clear, registered
- LAST_WRD  out  1  end-of-event marker, registered
- STALL  out  1  high while in Pause
- SAMPLE_CNT  out  SCNT_W  samples completed in the current event
- TMR_ERR  out  1  sticky flag: state replicas disagreed
- FRM_STATE  out  3  voted state, for debug

## Operation
States and encodings: Idle 000, Last_Word 001, Read 010, Strt_Sample 011, Tail_End 100, Tail_No_End 101, W4Data 110, Pause 111.

Transitions (s = current voted sequence count):
- Idle → W4Data if !L1A_BUF_MT.
- W4Data → Strt_Sample if !F_MT.
- Strt_Sample → Read.
- Read:
  - s==DATA_WORDS-1 and END_EVT → Tail_End
  - s==DATA_WORDS-1 and !END_EVT → Tail_No_End
  - F_MT → Pause
  - otherwise stay in Read
- Pause → Read if !F_MT.
- Tail_End → Last_Word when s==DATA_WORDS+TAIL_WORDS-1.
- Tail_No_End → W4Data when s==DATA_WORDS+TAIL_WORDS-1.
- Last_Word → Idle.
- Unused codes cannot occur; any decode miss → Idle.

Outputs are registered on the next-state decode, so they align with the state being entered:
- Strt_Sample: RD=1, VALID=1, SEQ=0.
- Read: RD=1, VALID=1, SEQ=s+1.
- Pause: RD=0, VALID=0, STALL=1, SEQ held.
- Tail_*: VALID=1, SEQ=s+1.
- W4Data: CLR_CRC=1.
- Last_Word: LAST_WRD=1, SEQ=0.
- All other states: all strobes 0, SEQ=0.

SAMPLE_CNT:
- increments (wrapping at 2^SCNT_W) on entry to W4Data or Last_Word from a Tail state;
- cleared on entry to Idle.

TMR:
- TMR=1: state, sequence counter, SAMPLE_CNT and every output register are triplicated. Each replica's next state is computed from voted values.
- TMR_ERR sets when any state or sequence replica differs from the vote. It is held until CLR_TMR_ERR=1 (clear takes priority over a simultaneous set).

Arithmetic: the sequence counter is SEQ_W bits and is never allowed to wrap; the Tail terminal compare bounds it.

## Timing
- Reset (RST_N low, asynchronous) puts the block in Idle with RD=VALID=CLR_CRC=LAST_WRD=STALL=TMR_ERR=0, SEQ=0, SAMPLE_CNT=0.
- Reset asserted mid-frame aborts the frame immediately; no LAST_WRD is emitted.
- Latency:
  - Idle with L1A_BUF_MT falling → CLR_CRC high 1 cycle later;
  - W4Data with F_MT low → first RD/VALID (SEQ=0) 1 cycle later.
- An unpaused sample is DATA_WORDS+TAIL_WORDS consecutive VALID cycles, and RD is high for the first DATA_WORDS of them.
- Pause is entered in the cycle after F_MT is seen high in Read. No RD is issued while F_MT=1. Resume inserts no extra bubble beyond the cycles F_MT was high.
- F_MT high on the final data word (s==DATA_WORDS-1) is ignored; the Tail has priority.
- END_EVT is evaluated only on the s==DATA_WORDS-1 Read cycle.
- Back-to-back samples pass through W4Data with 1 cycle of CLR_CRC.

## Test plan
- Defaults, one sample with END_EVT=1, FIFO never empty → CLR_CRC, then 100 VALID cycles with SEQ 0..99, RD high for SEQ 0..95, then LAST_WRD 1 cycle, back in Idle, SAMPLE_CNT 0→1→0.
- Two samples, END_EVT=0 then 1 → 100 VALID, 1 CLR_CRC cycle, 100 VALID, LAST_WRD; SAMPLE_CNT reads 2 on the LAST_WRD cycle.
- F_MT high 3 cycles after SEQ=40 → STALL high 3 cycles, RD/VALID low, SEQ holds 40, resumes at 41; total RD count still 96.
- DATA_WORDS=16, TAIL_WORDS=2, SEQ_W=5 → 18-word frame, SEQ 0..17, RD on 0..15.
- TMR=1, force one state replica flip at SEQ=10 → frame unaffected, TMR_ERR=1 next cycle and held; CLR_TMR_ERR pulse → 0.
- RST_N low at SEQ=50 → all outputs 0 asynchronously; after release the block restarts from Idle.

Source files
------------

// File: rtl/chnlnk_frame_fsm_p.sv
// chnlnk_frame_fsm_p: parametrised channel-link frame sequencer (data + tail words, pause on
// FIFO underrun, per-event sample count) with optional triplicated, majority-voted state.
module chnlnk_frame_fsm_p #(
   parameter int DATA_WORDS = 96,
   parameter int TAIL_WORDS = 4,
   parameter int SEQ_W      = 7,
   parameter int SCNT_W     = 5,
   parameter bit TMR        = 1'b1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              L1A_BUF_MT,
   input  logic              F_MT,
   input  logic              END_EVT,
   input  logic              CLR_TMR_ERR,
   output logic              RD,
   output logic              VALID,
   output logic [SEQ_W-1:0]  SEQ,
   output logic              CLR_CRC,
   output logic              LAST_WRD,
   output logic              STALL,
   output logic [SCNT_W-1:0] SAMPLE_CNT,
   output logic              TMR_ERR,
   output logic [2:0]        FRM_STATE
);
   typedef enum logic [2:0] {
      IDLE        = 3'b000,
      LAST_WORD   = 3'b001,
      READ        = 3'b010,
      STRT_SAMPLE = 3'b011,
      TAIL_END    = 3'b100,
      TAIL_NO_END = 3'b101,
      W4DATA      = 3'b110,
      PAUSE       = 3'b111
   } state_t;

   localparam int N  = TMR ? 3 : 1;
   localparam int RW = 3 + SEQ_W + SCNT_W + 6;
   localparam logic [SEQ_W-1:0] LAST_DATA = SEQ_W'(DATA_WORDS - 1);
   localparam logic [SEQ_W-1:0] LAST_TAIL = SEQ_W'(DATA_WORDS + TAIL_WORDS - 1);

   logic [RW-1:0]     w_rep [N];
   logic [RW-1:0]     w_vote;
   state_t            w_state, w_nx;
   logic [SEQ_W-1:0]  w_seq, w_nx_seq;
   logic [SCNT_W-1:0] w_scnt, w_nx_scnt;
   logic [4:0]        w_nx_out;
   logic              w_err, w_mis, w_nx_err, w_tail;

   assign w_state    = state_t'(w_vote[RW-1 -: 3]);
   assign w_seq      = w_vote[RW-4 -: SEQ_W];
   assign w_scnt     = w_vote[6 +: SCNT_W];
   assign {RD, VALID, CLR_CRC, LAST_WRD, STALL, w_err} = w_vote[5:0];
   assign SEQ        = w_seq;
   assign SAMPLE_CNT = w_scnt;
   assign TMR_ERR    = w_err;
   assign FRM_STATE  = w_state;

   always_comb begin
      w_nx = IDLE;
      case (w_state)
         IDLE:        w_nx = L1A_BUF_MT ? IDLE : W4DATA;
         W4DATA:      w_nx = F_MT ? W4DATA : STRT_SAMPLE;
         STRT_SAMPLE: w_nx = READ;
         READ:        w_nx = (w_seq == LAST_DATA) ? (END_EVT ? TAIL_END : TAIL_NO_END) : F_MT ? PAUSE : READ;
         PAUSE:       w_nx = F_MT ? PAUSE : READ;
         TAIL_END:    w_nx = (w_seq == LAST_TAIL) ? LAST_WORD : TAIL_END;
         TAIL_NO_END: w_nx = (w_seq == LAST_TAIL) ? W4DATA : TAIL_NO_END;
         LAST_WORD:   w_nx = IDLE;
         default:     w_nx = IDLE;
      endcase
   end

   // outputs are decoded from the state being entered so they register alongside it
   assign w_tail    = (w_state == TAIL_END) || (w_state == TAIL_NO_END);
   assign w_nx_seq  = (w_nx == READ || w_nx == TAIL_END || w_nx == TAIL_NO_END) ? w_seq + SEQ_W'(1) :
                      (w_nx == PAUSE) ? w_seq : '0;
   assign w_nx_scnt = (w_nx == IDLE) ? '0 :
                      (w_tail && (w_nx == W4DATA || w_nx == LAST_WORD)) ? w_scnt + SCNT_W'(1) : w_scnt;
   assign w_nx_out  = {w_nx == STRT_SAMPLE || w_nx == READ,
                       w_nx == STRT_SAMPLE || w_nx == READ || w_nx == TAIL_END || w_nx == TAIL_NO_END,
                       w_nx == W4DATA, w_nx == LAST_WORD, w_nx == PAUSE};
   assign w_nx_err  = !CLR_TMR_ERR && (w_err || w_mis);

   for (genvar i = 0; i < N; i++) begin : g_rep
      logic [2:0]        r_state;
      logic [SEQ_W-1:0]  r_seq;
      logic [SCNT_W-1:0] r_scnt;
      logic [5:0]        r_out;
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_state <= IDLE;
            r_seq   <= '0;
            r_scnt  <= '0;
            r_out   <= '0;
         end else begin
            r_state <= w_nx;
            r_seq   <= w_nx_seq;
            r_scnt  <= w_nx_scnt;
            r_out   <= {w_nx_out, w_nx_err};
         end
      end
      assign w_rep[i] = {r_state, r_seq, r_scnt, r_out};
   end

   if (TMR) begin : g_tmr
      assign w_vote = (w_rep[0] & w_rep[1]) | (w_rep[0] & w_rep[2]) | (w_rep[1] & w_rep[2]);
      assign w_mis  = (w_rep[0][RW-1 -: 3+SEQ_W] != w_vote[RW-1 -: 3+SEQ_W]) ||
                      (w_rep[1][RW-1 -: 3+SEQ_W] != w_vote[RW-1 -: 3+SEQ_W]) ||
                      (w_rep[2][RW-1 -: 3+SEQ_W] != w_vote[RW-1 -: 3+SEQ_W]);
   end else begin : g_one
      assign w_vote = w_rep[0];
      assign w_mis  = 1'b0;
   end
endmodule

// File: tb/tb_chnlnk_frame_fsm_p.sv
// tb_chnlnk_frame_fsm_p: scoreboard bench; expected output words are queued ahead of stimulus
// and a negedge monitor pops one per cycle in which the DUT shows any strobe.
module tb_chnlnk_frame_fsm_p;
   typedef struct packed {
      logic       rd, valid, clr, last, stall;
      logic [6:0] seq;
      logic [4:0] scnt;
   } item_t;

   logic clk = 1'b0;
   logic rst_n, l1a_mt, f_mt, end_evt, clr_err;
   logic rd, valid, clr_crc, last_wrd, stall, tmr_err;
   logic [6:0] seq;
   logic [4:0] scnt;
   logic [2:0] frm;
   logic l1a_s, f_s, end_s, clr_s;
   logic rd_s, valid_s, clr_crc_s, last_s, stall_s, err_s;
   logic [4:0] seq_s;
   logic [4:0] scnt_s;
   logic [2:0] frm_s;

   item_t q[$], qs[$];
   item_t got_m, exp_m, got_s, exp_s;
   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   chnlnk_frame_fsm_p dut (
      .CLK(clk), .RST_N(rst_n), .L1A_BUF_MT(l1a_mt), .F_MT(f_mt), .END_EVT(end_evt),
      .CLR_TMR_ERR(clr_err), .RD(rd), .VALID(valid), .SEQ(seq), .CLR_CRC(clr_crc),
      .LAST_WRD(last_wrd), .STALL(stall), .SAMPLE_CNT(scnt), .TMR_ERR(tmr_err), .FRM_STATE(frm)
   );

   chnlnk_frame_fsm_p #(.DATA_WORDS(16), .TAIL_WORDS(2), .SEQ_W(5), .SCNT_W(5), .TMR(1'b0)) dut_s (
      .CLK(clk), .RST_N(rst_n), .L1A_BUF_MT(l1a_s), .F_MT(f_s), .END_EVT(end_s),
      .CLR_TMR_ERR(clr_s), .RD(rd_s), .VALID(valid_s), .SEQ(seq_s), .CLR_CRC(clr_crc_s),
      .LAST_WRD(last_s), .STALL(stall_s), .SAMPLE_CNT(scnt_s), .TMR_ERR(err_s), .FRM_STATE(frm_s)
   );

   always @(negedge clk) begin
      if (rst_n && (rd || valid || clr_crc || last_wrd || stall)) begin
         got_m = {rd, valid, clr_crc, last_wrd, stall, seq, scnt};
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL sb_word got %h want none", got_m);
         end else begin
            exp_m = q.pop_front();
            if (got_m !== exp_m) begin
               n_err++;
               $display("FAIL sb_word got %h want %h", got_m, exp_m);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (rd_s || valid_s || clr_crc_s || last_s || stall_s)) begin
         got_s = {rd_s, valid_s, clr_crc_s, last_s, stall_s, 2'b00, seq_s, scnt_s};
         n_vec++;
         if (qs.size() == 0) begin
            n_err++;
            $display("FAIL sb_small got %h want none", got_s);
         end else begin
            exp_s = qs.pop_front();
            if (got_s !== exp_s) begin
               n_err++;
               $display("FAIL sb_small got %h want %h", got_s, exp_s);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic item_t mk(input logic r, v, c, l, s, input int sq, input int cn);
      return {r, v, c, l, s, 7'(sq), 5'(cn)};
   endfunction

   task automatic push_item(input bit s, input item_t it);
      if (s) qs.push_back(it);
      else q.push_back(it);
   endtask

   task automatic push_sample(input bit s, input int dw, input int tw, input int cnt,
                              input int upto, input int pause_at, input int pause_n);
      push_item(s, mk(0, 0, 1, 0, 0, 0, cnt));
      for (int k = 0; k < dw + tw && k <= upto; k++) begin
         push_item(s, mk(k < dw, 1, 0, 0, 0, k, cnt));
         if (k == pause_at)
            for (int j = 0; j < pause_n; j++) push_item(s, mk(0, 0, 0, 0, 1, k, cnt));
      end
   endtask

   task automatic start();
      @(negedge clk);
      l1a_mt = 1'b0;
      @(negedge clk);
      l1a_mt = 1'b1;
      chk("clr_crc_latency", clr_crc, 1);
   endtask

   task automatic wait_seq(input int sq);
      int k = 0;
      while (!(valid && seq == 7'(sq)) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("reach_seq", valid && seq == 7'(sq), 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((q.size() != 0 || frm != 3'd0) && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("queue_drained", q.size(), 0);
      chk("idle_state", frm, 0);
      chk("idle_sample_cnt", scnt, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst_n = 1'b0; l1a_mt = 1'b1; f_mt = 1'b0; end_evt = 1'b1; clr_err = 1'b0;
      l1a_s = 1'b1; f_s = 1'b0; end_s = 1'b1; clr_s = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rd", rd, 0);
      chk("rst_valid", valid, 0);
      chk("rst_clr_crc", clr_crc, 0);
      chk("rst_last", last_wrd, 0);
      chk("rst_stall", stall, 0);
      chk("rst_seq", seq, 0);
      chk("rst_scnt", scnt, 0);
      chk("rst_tmr_err", tmr_err, 0);
      chk("rst_state", frm, 0);
      chk("rst_small_state", frm_s, 0);
      rst_n = 1'b1;

      // single sample ending its event
      push_sample(0, 96, 4, 0, 999, -1, 0);
      push_item(0, mk(0, 0, 0, 1, 0, 0, 1));
      start();
      wait_idle();

      // two samples: END_EVT low for the first, high for the second
      end_evt = 1'b0;
      push_sample(0, 96, 4, 0, 999, -1, 0);
      push_sample(0, 96, 4, 1, 999, -1, 0);
      push_item(0, mk(0, 0, 0, 1, 0, 0, 2));
      start();
      repeat (150) @(negedge clk);
      end_evt = 1'b1;
      wait_idle();

      // FIFO underrun for 3 cycles after SEQ 40
      push_sample(0, 96, 4, 0, 999, 40, 3);
      push_item(0, mk(0, 0, 0, 1, 0, 0, 1));
      start();
      wait_seq(40);
      f_mt = 1'b1;
      repeat (3) @(negedge clk);
      f_mt = 1'b0;
      wait_idle();

      // reduced geometry on the single-copy instance
      push_sample(1, 16, 2, 0, 999, -1, 0);
      push_item(1, mk(0, 0, 0, 1, 0, 0, 1));
      @(negedge clk);
      l1a_s = 1'b0;
      @(negedge clk);
      l1a_s = 1'b1;
      for (int k = 0; k < 100 && (qs.size() != 0 || frm_s != 3'd0); k++) @(negedge clk);
      chk("small_drained", qs.size(), 0);
      chk("small_idle", frm_s, 0);
      chk("small_tmr_err", err_s, 0);

      // replica upset mid-frame; clear must win over a simultaneous set
      push_sample(0, 96, 4, 0, 999, -1, 0);
      push_item(0, mk(0, 0, 0, 1, 0, 0, 1));
      start();
      wait_seq(10);
      chk("tmr_err_before", tmr_err, 0);
      force dut.g_rep[1].r_state = 3'b111;
      clr_err = 1'b1;
      @(negedge clk);
      chk("tmr_clr_priority", tmr_err, 0);
      clr_err = 1'b0;
      @(negedge clk);
      chk("tmr_err_set", tmr_err, 1);
      release dut.g_rep[1].r_state;
      repeat (5) @(negedge clk);
      chk("tmr_err_held", tmr_err, 1);
      wait_idle();
      chk("tmr_err_held_idle", tmr_err, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("tmr_err_cleared", tmr_err, 0);

      // asynchronous reset at SEQ 50 aborts the frame
      push_sample(0, 96, 4, 0, 50, -1, 0);
      start();
      wait_seq(50);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rd", rd, 0);
      chk("arst_valid", valid, 0);
      chk("arst_seq", seq, 0);
      chk("arst_state", frm, 0);
      chk("arst_last", last_wrd, 0);
      chk("arst_queue", q.size(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_state", frm, 0);
      chk("post_rst_clr_crc", clr_crc, 0);
      push_sample(0, 96, 4, 0, 999, -1, 0);
      push_item(0, mk(0, 0, 0, 1, 0, 0, 1));
      start();
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
